serial_sub: RTL
===============

// Module: serial_sub
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: computes diff = a - b (mod 2^WIDTH) and the final borrow.
//   Built from one full-subtractor cell plus a borrow flip-flop; processes one bit per clock, LSB first.
//   It is the inverse-operation counterpart of the adder blocks in the adder library.
//   Parent logic uses it as a low-area arithmetic engine with a start/done handshake.
// PARAMETERS
//   WIDTH  8  operand and result width in bits (WIDTH >= 2)
// PORTS
//   clk         input   1      clock, rising edge
//   rst_n       input   1      asynchronous active-low reset
//   start       input   1      request; sampled high in IDLE or DONE loads operands
//   a           input   WIDTH  minuend, sampled only on an accepted start
//   b           input   WIDTH  subtrahend, sampled only on an accepted start
//   busy        output  1      high while in RUN
//   done        output  1      one-cycle pulse; result valid
//   diff        output  WIDTH  a - b mod 2^WIDTH, held after done until next accepted start
//   borrow_out  output  1      1 iff a < b (unsigned), held like diff
// BEHAVIOUR
//   Reset (rst_n low, any time, asynchronous):
//     - state=IDLE; busy=0, done=0, diff=0, borrow_out=0
//     - internal shift regs, bit counter and borrow FF cleared
//     - an in-flight operation is abandoned and produces no done
//   States: IDLE -> RUN -> DONE -> IDLE, or DONE -> RUN on start.
//   IDLE:
//     - start=1: load sa<=a, sb<=b, br<=0, cnt<=0, diff<=0, borrow_out<=0; go to RUN
//   RUN, each cycle, bit cell on x=sa[0], y=sb[0]:
//     - d = x ^ y ^ br
//     - br_next = (~x & y) | (~(x ^ y) & br)
//     - diff <= {d, diff[WIDTH-1:1]}; sa, sb shift right one bit; br <= br_next; cnt <= cnt+1
//     - on the cycle with cnt==WIDTH-1: borrow_out <= br_next; go to DONE
//     - start ignored; a and b may change freely
//   DONE (exactly one cycle):
//     - done=1, busy=0; diff and borrow_out final
//     - start=1: accepted exactly as in IDLE (back-to-back operation); else go to IDLE
//   Timing: start accepted at edge k -> busy high for cycles k+1..k+WIDTH, done high in cycle k+WIDTH+1.
//     - back-to-back throughput: one result per WIDTH+1 cycles
//   Outputs:
//     - registered; busy = (state==RUN), done = (state==DONE)
//     - diff shows partial shifted values during RUN and is valid only from done onward
//   Arithmetic:
//     - unsigned modulo 2^WIDTH; borrow_out equals the borrow out of the MSB
//     - no overflow flag; signed interpretation is the caller's responsibility
//   cnt width: $clog2(WIDTH) bits; the counter must not wrap before DONE.
// TESTING (WIDTH=8)
//   1. Reset, then a=5, b=3, start 1 cycle -> busy 8 cycles; done at k+9; diff=2, borrow_out=0
//   2. a=3, b=5 -> diff=8'hFE, borrow_out=1
//   3. a=0, b=0 -> diff=0, borrow_out=0; a=8'hFF, b=8'hFF -> diff=0, borrow_out=0
//   4. a=0, b=1 -> diff=8'hFF, borrow_out=1 (borrow ripples through all bits)
//   5. Start plus changed a/b during RUN -> ignored; result matches the first operands.
//      Start in the DONE cycle -> new run begins; done again 9 cycles later.
//   6. Pull rst_n low in the 4th RUN cycle -> outputs 0 immediately, no done.
//      After release, a=100, b=37 -> diff=63, borrow_out=0.
//   Also: random sweep of 1000 operand pairs vs. reference model (a-b) & 8'hFF and (a<b).

Source files
------------

// File: rtl/serial_sub.sv
`timescale 1ns/1ps
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, start/done handshake; diff = a - b mod 2^WIDTH, borrow_out = (a < b).
//
// state | meaning
// IDLE  | waiting for start, result registers hold last value
// RUN   | one difference bit produced per clock
// DONE  | single-cycle result-valid pulse, start accepted back-to-back
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             x, y, d_bit, br_nx;

  always_comb begin
    x     = sa_q[0];
    y     = sb_q[0];
    d_bit = x ^ y ^ br_q;
    br_nx = (~x & y) | (~(x ^ y) & br_q);
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        br_d   = br_nx;
        cnt_d  = cnt_q + 1'b1;
        // last bit: the borrow leaving the MSB is the unsigned a < b flag
        if (cnt_q == CW'(WIDTH - 1)) begin
          bout_d  = br_nx;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
